// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, sequencer state encoding, control word.
package cpu_pkg;

  // The datapath ALU performs the PC increment, so this value is informational.
  localparam int PC_STEP = 1;

  // ALU operation used for PC increment, address and immediate adds.
  localparam logic [4:0] ADD_OP = 5'b00011;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_RST  = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_T7   = 4'd8,
    ST_HALT = 4'd9
  } state_t;

  // One datapath control word: every strobe plus the ALU operation select.
  typedef struct packed {
    logic       read;
    logic       write;
    logic       inc_pc;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic       pc_in;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       y_in;
    logic       z_in;
    logic       pc_out;
    logic       mdr_out;
    logic       zlow_out;
    logic       c_out;
    logic [4:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // Register-register ALU instructions; their opcode doubles as the ALU select.
  function automatic logic is_rformat(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Any opcode the sequencer knows how to execute.
  function automatic logic is_defined(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST) || is_rformat(op) ||
           (op == OP_ADDI) || (op == OP_NOP) || (op == OP_HALT);
  endfunction

  // Instructions whose final step is T5.
  function automatic logic ends_at_t5(input logic [4:0] op);
    return (op == OP_LDI) || (op == OP_ADDI) || is_rformat(op);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps fetch/execute T0..T7 and drives datapath strobes.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        Stop,
  output logic        Run,
  output logic        Illegal,
  output logic [4:0]  opcode,
  output logic        Read,
  output logic        Write,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zlowout,
  output logic        Cout
);

  state_t     state_q;
  state_t     state_d;
  logic       last_step;
  ctrl_t      ctrl;
  logic [4:0] ir_op;
  logic       ir_unused_bits;

  assign ir_op          = IR[31:27];
  assign ir_unused_bits = ^IR[26:0];

  // State register; clear low returns to RST from anywhere, even mid-instruction.
  always_ff @(posedge Clock) begin
    if (!clear) begin
      state_q <= ST_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-step sequencing; Stop only matters on an instruction's final step.
  always_comb begin
    state_d   = state_q;
    last_step = 1'b0;
    case (state_q)
      ST_RST: state_d = ST_T0;
      ST_T0:  state_d = ST_T1;
      ST_T1:  state_d = ST_T2;
      ST_T2:  state_d = ST_T3;
      ST_T3: begin
        if (ir_op == OP_HALT) begin
          state_d = ST_HALT;
        end else if ((ir_op == OP_NOP) || !is_defined(ir_op)) begin
          last_step = 1'b1;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T4:  state_d = ST_T5;
      ST_T5: begin
        if (ends_at_t5(ir_op)) begin
          last_step = 1'b1;
        end else begin
          state_d = ST_T6;
        end
      end
      ST_T6:   state_d = ST_T7;
      ST_T7:   last_step = 1'b1;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RST;
    endcase
    if (last_step) begin
      state_d = Stop ? ST_HALT : ST_T0;
    end
  end

  // Control word decode from the current step and the opcode in IR.
  always_comb begin
    ctrl = CTRL_IDLE;
    case (state_q)
      ST_T0: begin
        ctrl.pc_out = 1'b1;
        ctrl.mar_in = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.z_in   = 1'b1;
        ctrl.alu_op = ADD_OP;
      end
      ST_T1: begin
        ctrl.zlow_out = 1'b1;
        ctrl.pc_in    = 1'b1;
        ctrl.read     = 1'b1;
        ctrl.mdr_in   = 1'b1;
      end
      ST_T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_in   = 1'b1;
      end
      ST_T3: begin
        if ((ir_op == OP_LD) || (ir_op == OP_LDI) || (ir_op == OP_ST)) begin
          ctrl.grb    = 1'b1;
          ctrl.ba_out = 1'b1;
          ctrl.y_in   = 1'b1;
        end else if (is_rformat(ir_op) || (ir_op == OP_ADDI)) begin
          ctrl.grb  = 1'b1;
          ctrl.rout = 1'b1;
          ctrl.y_in = 1'b1;
        end
      end
      ST_T4: begin
        if (is_rformat(ir_op)) begin
          ctrl.grc    = 1'b1;
          ctrl.rout   = 1'b1;
          ctrl.alu_op = ir_op;
          ctrl.z_in   = 1'b1;
        end else if ((ir_op == OP_LD) || (ir_op == OP_LDI) ||
                     (ir_op == OP_ST) || (ir_op == OP_ADDI)) begin
          ctrl.c_out  = 1'b1;
          ctrl.alu_op = ADD_OP;
          ctrl.z_in   = 1'b1;
        end
      end
      ST_T5: begin
        if ((ir_op == OP_LD) || (ir_op == OP_ST)) begin
          ctrl.zlow_out = 1'b1;
          ctrl.mar_in   = 1'b1;
        end else if (ends_at_t5(ir_op)) begin
          ctrl.zlow_out = 1'b1;
          ctrl.gra      = 1'b1;
          ctrl.rin      = 1'b1;
        end
      end
      ST_T6: begin
        if (ir_op == OP_LD) begin
          ctrl.read   = 1'b1;
          ctrl.mdr_in = 1'b1;
        end else if (ir_op == OP_ST) begin
          // Read stays low so the MDR takes the register value from the bus.
          ctrl.gra    = 1'b1;
          ctrl.rout   = 1'b1;
          ctrl.mdr_in = 1'b1;
        end
      end
      ST_T7: begin
        if (ir_op == OP_LD) begin
          ctrl.mdr_out = 1'b1;
          ctrl.gra     = 1'b1;
          ctrl.rin     = 1'b1;
        end else if (ir_op == OP_ST) begin
          ctrl.write = 1'b1;
        end
      end
      default: ctrl = CTRL_IDLE;
    endcase
  end

  assign Run     = (state_q != ST_RST) && (state_q != ST_HALT);
  assign Illegal = (state_q == ST_T3) && !is_defined(ir_op);

  assign opcode  = ctrl.alu_op;
  assign Read    = ctrl.read;
  assign Write   = ctrl.write;
  assign IncPC   = ctrl.inc_pc;
  assign Gra     = ctrl.gra;
  assign Grb     = ctrl.grb;
  assign Grc     = ctrl.grc;
  assign Rin     = ctrl.rin;
  assign Rout    = ctrl.rout;
  assign BAout   = ctrl.ba_out;
  assign PCin    = ctrl.pc_in;
  assign IRin    = ctrl.ir_in;
  assign MARin   = ctrl.mar_in;
  assign MDRin   = ctrl.mdr_in;
  assign Yin     = ctrl.y_in;
  assign Zin     = ctrl.z_in;
  assign PCout   = ctrl.pc_out;
  assign MDRout  = ctrl.mdr_out;
  assign Zlowout = ctrl.zlow_out;
  assign Cout    = ctrl.c_out;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer with hand-computed control words.
module tb_control_sequencer;

  logic        Clock;
  logic        clear;
  logic [31:0] IR;
  logic        Stop;
  logic        Run, Illegal;
  logic [4:0]  opcode;
  logic        Read, Write, IncPC;
  logic        Gra, Grb, Grc, Rin, Rout, BAout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin;
  logic        PCout, MDRout, Zlowout, Cout;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .Clock(Clock), .clear(clear), .IR(IR), .Stop(Stop),
    .Run(Run), .Illegal(Illegal), .opcode(opcode),
    .Read(Read), .Write(Write), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
    .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .Cout(Cout)
  );

  // Observed control word: Run, Illegal, opcode, then the 19 strobes.
  logic [25:0] obs;
  assign obs = {Run, Illegal, opcode, Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
                PCin, IRin, MARin, MDRin, Yin, Zin, PCout, MDRout, Zlowout, Cout};

  localparam logic [25:0] B_RUN   = 26'd1 << 25;
  localparam logic [25:0] B_ILL   = 26'd1 << 24;
  localparam logic [25:0] B_READ  = 26'd1 << 18;
  localparam logic [25:0] B_WRITE = 26'd1 << 17;
  localparam logic [25:0] B_INCPC = 26'd1 << 16;
  localparam logic [25:0] B_GRA   = 26'd1 << 15;
  localparam logic [25:0] B_GRB   = 26'd1 << 14;
  localparam logic [25:0] B_GRC   = 26'd1 << 13;
  localparam logic [25:0] B_RIN   = 26'd1 << 12;
  localparam logic [25:0] B_ROUT  = 26'd1 << 11;
  localparam logic [25:0] B_BAOUT = 26'd1 << 10;
  localparam logic [25:0] B_PCIN  = 26'd1 << 9;
  localparam logic [25:0] B_IRIN  = 26'd1 << 8;
  localparam logic [25:0] B_MARIN = 26'd1 << 7;
  localparam logic [25:0] B_MDRIN = 26'd1 << 6;
  localparam logic [25:0] B_YIN   = 26'd1 << 5;
  localparam logic [25:0] B_ZIN   = 26'd1 << 4;
  localparam logic [25:0] B_PCOUT = 26'd1 << 3;
  localparam logic [25:0] B_MDROUT= 26'd1 << 2;
  localparam logic [25:0] B_ZLOW  = 26'd1 << 1;
  localparam logic [25:0] B_COUT  = 26'd1;
  localparam logic [25:0] OP_ADDF = {2'b00, 5'b00011, 19'd0};
  localparam logic [25:0] OP_SUBF = {2'b00, 5'b00100, 19'd0};

  localparam logic [25:0] W_ZERO = 26'd0;
  localparam logic [25:0] W_F0   = B_RUN | B_PCOUT | B_MARIN | B_INCPC | B_ZIN | OP_ADDF;
  localparam logic [25:0] W_F1   = B_RUN | B_ZLOW | B_PCIN | B_READ | B_MDRIN;
  localparam logic [25:0] W_F2   = B_RUN | B_MDROUT | B_IRIN;
  localparam logic [25:0] W_LD3  = B_RUN | B_GRB | B_BAOUT | B_YIN;
  localparam logic [25:0] W_LD4  = B_RUN | B_COUT | B_ZIN | OP_ADDF;
  localparam logic [25:0] W_LD5  = B_RUN | B_ZLOW | B_MARIN;
  localparam logic [25:0] W_LD6  = B_RUN | B_READ | B_MDRIN;
  localparam logic [25:0] W_LD7  = B_RUN | B_MDROUT | B_GRA | B_RIN;
  localparam logic [25:0] W_ST6  = B_RUN | B_GRA | B_ROUT | B_MDRIN;
  localparam logic [25:0] W_ST7  = B_RUN | B_WRITE;
  localparam logic [25:0] W_R3   = B_RUN | B_GRB | B_ROUT | B_YIN;
  localparam logic [25:0] W_SUB4 = B_RUN | B_GRC | B_ROUT | B_ZIN | OP_SUBF;
  localparam logic [25:0] W_WB5  = B_RUN | B_ZLOW | B_GRA | B_RIN;
  localparam logic [25:0] W_NOP3 = B_RUN;
  localparam logic [25:0] W_ILL3 = B_RUN | B_ILL;

  // Free-running clock.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Pulse clear low for one edge; the DUT sits in RST afterwards, T0 after the next edge.
  task automatic recover();
    clear = 1'b0;
    tick();
    clear = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    clear = 1'b0; Stop = 1'b0; IR = 32'd0;
    tick();
    tick();
    checks++;
    if (obs !== W_ZERO) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", obs, W_ZERO);
    end
    clear = 1'b1;
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL reset_release_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_ld();
    logic [25:0] exp [8];
    exp = '{W_F0, W_F1, W_F2, W_LD3, W_LD4, W_LD5, W_LD6, W_LD7};
    IR = {5'b00000, 4'd2, 4'd0, 19'h65};
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL ld_t%0d: got %h expected %h", i, obs, exp[i]);
      end
    end
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL ld_return_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_st();
    logic [25:0] exp [8];
    exp = '{W_F0, W_F1, W_F2, W_LD3, W_LD4, W_LD5, W_ST6, W_ST7};
    IR = {5'b00010, 4'd3, 4'd1, 19'h10};
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL st_t%0d: got %h expected %h", i, obs, exp[i]);
      end
      checks++;
      if ((Rout & BAout) !== 1'b0) begin
        errors++;
        $display("FAIL st_rout_baout_t%0d: got Rout=%b BAout=%b expected not both 1", i, Rout, BAout);
      end
    end
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL st_return_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_rformat();
    logic [25:0] exp [6];
    exp = '{W_F0, W_F1, W_F2, W_R3, W_SUB4, W_WB5};
    IR = {5'b00100, 4'd5, 4'd6, 4'd7, 15'd0};
    for (int i = 1; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL sub_t%0d: got %h expected %h", i, obs, exp[i]);
      end
    end
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL sub_return_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_ldi();
    logic [25:0] exp [6];
    exp = '{W_F0, W_F1, W_F2, W_LD3, W_LD4, W_WB5};
    IR = {5'b00001, 4'd4, 4'd0, 19'h3};
    for (int i = 1; i < 6; i++) begin
      tick();
      checks++;
      if (obs !== exp[i]) begin
        errors++;
        $display("FAIL ldi_t%0d: got %h expected %h", i, obs, exp[i]);
      end
    end
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL ldi_return_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_illegal();
    IR = {5'b11111, 27'd0};
    tick(); tick(); tick();
    checks++;
    if (obs !== W_ILL3) begin
      errors++;
      $display("FAIL illegal_t3: got %h expected %h", obs, W_ILL3);
    end
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL illegal_next_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_nop();
    IR = {5'b11010, 27'd0};
    tick(); tick(); tick();
    checks++;
    if (obs !== W_NOP3) begin
      errors++;
      $display("FAIL nop_t3: got %h expected %h", obs, W_NOP3);
    end
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL nop_next_t0: got %h expected %h", obs, W_F0);
    end
    // Stop on the single NOP step halts the sequencer.
    tick(); tick(); tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    checks++;
    if (obs !== W_ZERO) begin
      errors++;
      $display("FAIL nop_stop_halt: got %h expected %h", obs, W_ZERO);
    end
    recover();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL nop_recover_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_addi_stop_ignored();
    IR = {5'b01100, 4'd1, 4'd2, 19'd7};
    tick(); tick(); tick();
    checks++;
    if (obs !== W_R3) begin
      errors++;
      $display("FAIL addi_t3: got %h expected %h", obs, W_R3);
    end
    tick();
    checks++;
    if (obs !== W_LD4) begin
      errors++;
      $display("FAIL addi_t4: got %h expected %h", obs, W_LD4);
    end
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    checks++;
    if (obs !== W_WB5) begin
      errors++;
      $display("FAIL addi_t5: got %h expected %h", obs, W_WB5);
    end
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL addi_stop_ignored_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_addi_stop_halt();
    IR = {5'b01100, 4'd1, 4'd2, 19'd7};
    for (int i = 1; i < 6; i++) tick();
    checks++;
    if (obs !== W_WB5) begin
      errors++;
      $display("FAIL addi_halt_t5: got %h expected %h", obs, W_WB5);
    end
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    checks++;
    if (obs !== W_ZERO) begin
      errors++;
      $display("FAIL addi_stop_halt: got %h expected %h", obs, W_ZERO);
    end
    tick(); tick();
    checks++;
    if (obs !== W_ZERO) begin
      errors++;
      $display("FAIL halt_sticky: got %h expected %h", obs, W_ZERO);
    end
    recover();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL halt_recover_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_halt_opcode();
    IR = {5'b11011, 27'd0};
    tick(); tick(); tick();
    checks++;
    if (obs !== W_NOP3) begin
      errors++;
      $display("FAIL halt_op_t3: got %h expected %h", obs, W_NOP3);
    end
    tick();
    checks++;
    if (obs !== W_ZERO) begin
      errors++;
      $display("FAIL halt_op_state: got %h expected %h", obs, W_ZERO);
    end
    recover();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL halt_op_recover_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  task automatic test_reset_mid_ld();
    IR = {5'b00000, 4'd2, 4'd0, 19'h65};
    for (int i = 1; i < 6; i++) tick();
    checks++;
    if (obs !== W_LD5) begin
      errors++;
      $display("FAIL midreset_ld_t5: got %h expected %h", obs, W_LD5);
    end
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== W_ZERO) begin
        errors++;
        $display("FAIL midreset_hold_%0d: got %h expected %h", i, obs, W_ZERO);
      end
    end
    clear = 1'b1;
    tick();
    checks++;
    if (obs !== W_F0) begin
      errors++;
      $display("FAIL midreset_release_t0: got %h expected %h", obs, W_F0);
    end
  endtask

  // Scenario sequence; every scenario starts and ends with the DUT observed in T0.
  initial begin
    test_reset();
    test_ld();
    test_st();
    test_rformat();
    test_ldi();
    test_illegal();
    test_nop();
    test_addi_stop_ignored();
    test_addi_stop_halt();
    test_halt_opcode();
    test_reset_mid_ld();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit sitting directly upstream of `datapath`.
- Sequences fetch/execute steps T0..T7 and drives every datapath control strobe each clock, replacing hand-driven stimulus.
- Decodes the opcode from IR[31:27] (fed back from the datapath IR register).
- One step per clock; memory is single-cycle.

Parameters:
- PC_STEP, 1: informational only; IncPC is asserted, increment performed in datapath ALU.
- ADD_OP, 5'b00011: ALU opcode driven for address/immediate adds.

Ports:
- Clock  in  1  system clock, rising edge
- clear  in  1  synchronous, active-low reset; sampled on rising edge of Clock
- IR  in  32  instruction register contents from datapath; opcode = IR[31:27]
- Stop  in  1  request halt after current instruction completes
- Run  out  1  1 while sequencing, 0 in reset/HALT
- Illegal  out  1  one-cycle pulse at T3 for undefined opcode
- opcode  out  5  ALU operation select
- Read, Write, IncPC  out  1 each  memory read, memory write, PC increment
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select/enable
- PCin, IRin, MARin, MDRin, Yin, Zin  out  1 each  register load enables
- PCout, MDRout, Zlowout, Cout  out  1 each  bus drivers

Behaviour:
- State register: RST, T0..T7, HALT.
- Outputs are combinational from (state, IR[31:27]); no output is registered.
- clear=0 at an edge forces RST from any state, including mid-instruction. In RST all strobes=0, opcode=0, Run=0, Illegal=0. First edge with clear=1 moves RST->T0.
- Any state not listed below drives all strobes 0 and opcode 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin, opcode=ADD_OP.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - IR is valid from T3 onward; all opcode-dependent decode happens in T3..T7.
- Opcodes (package constants): LD=00000, LDI=00001, ST=00010, ADD=00011, SUB=00100, AND=00101, OR=00110, ADDI=01100, NOP=11010, HALT=11011.
- ld (LD, T3..T7):
  - T3: Grb, BAout, Yin.
  - T4: Cout, opcode=ADD_OP, Zin.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, Gra, Rin.
- ldi (LDI, T3..T5): T3/T4 as LD; T5: Zlowout, Gra, Rin.
- st (ST, T3..T7):
  - T3..T5 as LD.
  - T6: Gra, Rout, MDRin with Read=0, so MDR loads from the bus.
  - T7: Write.
- R-format (ADD/SUB/AND/OR, T3..T5):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, opcode=IR[31:27], Zin.
  - T5: Zlowout, Gra, Rin.
- ADDI (T3..T5):
  - T3: Grb, Rout, Yin.
  - T4: Cout, opcode=ADD_OP, Zin.
  - T5: Zlowout, Gra, Rin.
- NOP: T3 drives nothing.
- Undefined opcode: T3 drives nothing except Illegal=1; treated as NOP.
- HALT: T3 drives nothing; next state HALT.
- HALT state: all strobes 0, Run=0; leaves only via clear=0.
- Last step of an instruction: LD/ST T7; LDI/R-format/ADDI T5; NOP/illegal T3.
  - Next state is T0, unless Stop=1 sampled on that edge, then HALT.
  - Stop in any other step is ignored (not latched).
- Invariants:
  - Rout and BAout are never both 1.
  - Read and Write are never both 1.
  - Exactly one bus driver (PCout, MDRout, Zlowout, Cout, Rout, BAout) active per step, or none.
- Latency: LD/ST = 8 cycles, LDI/R/ADDI = 6, NOP = 4, counted T0-to-T0.

Decomposition:
- Shared package cpu_pkg: opcode localparams, state encoding (4-bit), ADD_OP.
- Reused by datapath ALU and future branch/jump extensions.
- No sub-module is natural; a single FSM with a separate output-decode always block.

Test Plan:
- Reset: hold clear=0 for 3 cycles mid-T5 of an ld -> all outputs 0, Run=0. Release -> T0 next edge with PCout=MARin=IncPC=Zin=1.
- ld: IR={5'b00000,4'd2,4'd0,19'h65} -> over T3..T7: Grb+BAout+Yin, Cout+Zin (opcode=00011), Zlowout+MARin, Read+MDRin, MDRout+Gra+Rin. Then T0; 8 cycles total.
- st: IR={5'b00010,4'd3,4'd1,19'h10} -> T6 Gra+Rout+MDRin with Read=0; T7 Write=1 only; Rout/BAout never both high.
- R-format: IR={5'b00100,4'd5,4'd6,4'd7,15'd0} -> T4 opcode=00100 with Grc+Rout+Zin; T5 Gra+Rin; back to T0 after 6 cycles.
- Stop/HALT:
  - Stop=1 during T4 of ADDI, dropped at T5 edge -> returns to T0 (ignored).
  - Stop=1 at T5 edge -> HALT, Run=0.
  - IR opcode 11011 -> HALT after T3.
- Illegal: IR[31:27]=11111 -> Illegal=1 for exactly the T3 cycle, no strobes, next state T0.
